ar_arbiter: RTL

Read-address (AR) channel arbiter and router of the AXI interconnect, the sequencing partner of the read-data return mux. It arbitrates AR requests from two masters (M0, M1) with round-robin priority, decodes ARADDR to one of six slaves or the default slave, and forwards the request with an extended ID carrying the one-hot master tag in bits [5:4]. The read-data mux uses that tag to route responses back. The arbiter also limits each master to one outstanding read burst by watching R-channel completion.

---
 rtl/ar_arbiter_pkg.sv | 40 ++++
 rtl/ar_arbiter_if.sv | 48 ++++
 rtl/ar_addr_decode.sv | 25 ++
 rtl/ar_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/ar_arbiter_pkg.sv
// Shared types and constants for the AR-channel arbiter/router.
// Contents: slave select enum, address map, master tags, FSM state enum,
// inclusive range helper.
package axi_ar_pkg;

  localparam int unsigned AXI_ID_BITS   = 4;
  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned NUM_M         = 2;
  localparam int unsigned NUM_S         = 7;  // six slaves plus the default slave

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, SDEFAULT} slave_e;

  localparam logic [AXI_ADDR_BITS-1:0] S0_BASE  = 32'h0000_0000;
  localparam logic [AXI_ADDR_BITS-1:0] S0_LIMIT = 32'h0000_1FFF;
  localparam logic [AXI_ADDR_BITS-1:0] S1_BASE  = 32'h0001_0000;
  localparam logic [AXI_ADDR_BITS-1:0] S1_LIMIT = 32'h0001_FFFF;
  localparam logic [AXI_ADDR_BITS-1:0] S2_BASE  = 32'h0002_0000;
  localparam logic [AXI_ADDR_BITS-1:0] S2_LIMIT = 32'h0002_FFFF;
  localparam logic [AXI_ADDR_BITS-1:0] S3_BASE  = 32'h1000_0000;
  localparam logic [AXI_ADDR_BITS-1:0] S3_LIMIT = 32'h1000_03FF;
  localparam logic [AXI_ADDR_BITS-1:0] S4_BASE  = 32'h1001_0000;
  localparam logic [AXI_ADDR_BITS-1:0] S4_LIMIT = 32'h1001_03FF;
  localparam logic [AXI_ADDR_BITS-1:0] S5_BASE  = 32'h2000_0000;
  localparam logic [AXI_ADDR_BITS-1:0] S5_LIMIT = 32'h201F_FFFF;

  // One-hot master tag carried in the extended slave-side ID
  localparam logic [1:0] TAG_M0 = 2'b01;
  localparam logic [1:0] TAG_M1 = 2'b10;

  typedef enum logic {IDLE, BUSY} state_e;

  // Inclusive address range test
  function automatic logic in_range(input logic [AXI_ADDR_BITS-1:0] addr,
                                    input logic [AXI_ADDR_BITS-1:0] base,
                                    input logic [AXI_ADDR_BITS-1:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/ar_arbiter_if.sv
// AR-channel bundle between the two masters, the arbiter and the seven slaves.
// Master index 0/1 = M0/M1; slave index 0..5 = S0..S5, 6 = default slave.
// m_*: master AR request, arready back, R-channel completion observation.
// s_*: routed AR request to each slave, arready from each slave.
// Modport slave is the arbiter's view; modport master is the surrounding
// environment that drives requests and slave readies.
interface ar_arbiter_if
  import axi_ar_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_ID_BITS,
  parameter int unsigned IDS_W  = AXI_IDS_BITS,
  parameter int unsigned ADDR_W = AXI_ADDR_BITS
);
  logic [NUM_M-1:0][ID_W-1:0]   m_arid;
  logic [NUM_M-1:0][ADDR_W-1:0] m_araddr;
  logic [NUM_M-1:0][3:0]        m_arlen;
  logic [NUM_M-1:0][2:0]        m_arsize;
  logic [NUM_M-1:0][1:0]        m_arburst;
  logic [NUM_M-1:0]             m_arvalid;
  logic [NUM_M-1:0]             m_arready;
  logic [NUM_M-1:0]             m_rvalid;
  logic [NUM_M-1:0]             m_rready;
  logic [NUM_M-1:0]             m_rlast;

  logic [NUM_S-1:0][IDS_W-1:0]  s_arid;
  logic [NUM_S-1:0][ADDR_W-1:0] s_araddr;
  logic [NUM_S-1:0][3:0]        s_arlen;
  logic [NUM_S-1:0][2:0]        s_arsize;
  logic [NUM_S-1:0][1:0]        s_arburst;
  logic [NUM_S-1:0]             s_arvalid;
  logic [NUM_S-1:0]             s_arready;

  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_rvalid, m_rready, m_rlast,
    output m_arready,
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    input  s_arready
  );

  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_rvalid, m_rready, m_rlast,
    input  m_arready,
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    output s_arready
  );
endinterface

// File: rtl/ar_addr_decode.sv
// Combinational address decoder: ARADDR -> target slave.
// Ports: addr (in, ADDR_W), slv_c (out, slave_e; SDEFAULT when unmapped).
module ar_addr_decode
  import axi_ar_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_BITS
) (
  input  logic [ADDR_W-1:0] addr,
  output slave_e            slv_c
);

  logic [AXI_ADDR_BITS-1:0] a;
  assign a = AXI_ADDR_BITS'(addr);

  always_comb begin
    slv_c = SDEFAULT;
    if      (in_range(a, S0_BASE, S0_LIMIT)) slv_c = S0;
    else if (in_range(a, S1_BASE, S1_LIMIT)) slv_c = S1;
    else if (in_range(a, S2_BASE, S2_LIMIT)) slv_c = S2;
    else if (in_range(a, S3_BASE, S3_LIMIT)) slv_c = S3;
    else if (in_range(a, S4_BASE, S4_LIMIT)) slv_c = S4;
    else if (in_range(a, S5_BASE, S5_LIMIT)) slv_c = S5;
  end

endmodule

// File: rtl/ar_arbiter.sv
// AR-channel arbiter/router: round-robin between M0/M1, address decode to
// S0..S5/default, extended ID {tag, ARID}, one outstanding read per master.
// Ports: clk, rst (sync, active-low), bus (ar_arbiter_if.slave).
module ar_arbiter
  import axi_ar_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_ID_BITS,
  parameter int unsigned IDS_W  = AXI_IDS_BITS,
  parameter int unsigned ADDR_W = AXI_ADDR_BITS
) (
  input logic        clk,
  input logic        rst,
  ar_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             gnt_m_q, gnt_m_d;
  slave_e           gnt_s_q, gnt_s_d;
  logic             last_m_q, last_m_d;   // master granted most recently
  logic [NUM_M-1:0] outst_q, outst_d;

  logic [NUM_M-1:0] elig_c;
  logic             cand_c;
  slave_e           cand_s_c;

  logic [NUM_S-1:0][IDS_W-1:0]  s_arid_c;
  logic [NUM_S-1:0][ADDR_W-1:0] s_araddr_c;
  logic [NUM_S-1:0][3:0]        s_arlen_c;
  logic [NUM_S-1:0][2:0]        s_arsize_c;
  logic [NUM_S-1:0][1:0]        s_arburst_c;
  logic [NUM_S-1:0]             s_arvalid_c;
  logic [NUM_M-1:0]             m_arready_c;

  // Candidate master: the one not granted last when both are eligible
  always_comb begin
    elig_c = bus.m_arvalid & ~outst_q;
    if (&elig_c) cand_c = ~last_m_q;
    else         cand_c = elig_c[1];
  end

  ar_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
    .addr  (bus.m_araddr[cand_c]),
    .slv_c (cand_s_c)
  );

  // Next state, routing and completion tracking
  always_comb begin
    state_d     = state_q;
    gnt_m_d     = gnt_m_q;
    gnt_s_d     = gnt_s_q;
    last_m_d    = last_m_q;
    s_arid_c    = '0;
    s_araddr_c  = '0;
    s_arlen_c   = '0;
    s_arsize_c  = '0;
    s_arburst_c = '0;
    s_arvalid_c = '0;
    m_arready_c = '0;
    outst_d     = outst_q & ~(bus.m_rvalid & bus.m_rready & bus.m_rlast);

    case (state_q)
      IDLE: begin
        if (|elig_c) begin
          state_d = BUSY;
          gnt_m_d = cand_c;
          gnt_s_d = cand_s_c;
        end
      end
      BUSY: begin
        s_arvalid_c[gnt_s_q] = bus.m_arvalid[gnt_m_q];
        s_arid_c[gnt_s_q]    = IDS_W'({(gnt_m_q ? TAG_M1 : TAG_M0), bus.m_arid[gnt_m_q]});
        s_araddr_c[gnt_s_q]  = bus.m_araddr[gnt_m_q];
        s_arlen_c[gnt_s_q]   = bus.m_arlen[gnt_m_q];
        s_arsize_c[gnt_s_q]  = bus.m_arsize[gnt_m_q];
        s_arburst_c[gnt_s_q] = bus.m_arburst[gnt_m_q];
        m_arready_c[gnt_m_q] = bus.s_arready[gnt_s_q];
        // A dropped ARVALID leaves the grant in place and sets nothing
        if (bus.m_arvalid[gnt_m_q] && bus.s_arready[gnt_s_q]) begin
          state_d          = IDLE;
          outst_d[gnt_m_q] = 1'b1;
          last_m_d         = gnt_m_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset favours M0 by marking M1 as last granted
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_m_q  <= 1'b0;
      gnt_s_q  <= S0;
      last_m_q <= 1'b1;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_m_q  <= gnt_m_d;
      gnt_s_q  <= gnt_s_d;
      last_m_q <= last_m_d;
      outst_q  <= outst_d;
    end
  end

  assign bus.s_arid    = s_arid_c;
  assign bus.s_araddr  = s_araddr_c;
  assign bus.s_arlen   = s_arlen_c;
  assign bus.s_arsize  = s_arsize_c;
  assign bus.s_arburst = s_arburst_c;
  assign bus.s_arvalid = s_arvalid_c;
  assign bus.m_arready = m_arready_c;

endmodule
